// File: rtl/core_pkg.sv
// core_pkg: definitions shared by the ATtiny20 core pipeline stages.
//   ADDR_WIDTH  default program-word address width (must match the ROM)
//   DATA_WIDTH  default instruction word width
//   INSTR_NOP   encoding of the AVR "nop" instruction
//   fetch_state_t  fetch stage state machine encoding
package core_pkg;

    localparam int ADDR_WIDTH = 8;
    localparam int DATA_WIDTH = 16;

    localparam logic [15:0] INSTR_NOP = 16'h0000;

    typedef enum logic [0:0] {
        ST_PRIME = 1'b0,   // ROM has not yet latched a word for address 0
        ST_RUN   = 1'b1    // normal fetch
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage of the ATtiny20 core.
// Owns the program counter, drives the ROM address and captures the returned
// word into the instruction register for the decoder. The ROM latches on the
// falling edge, so a word addressed at rising edge k is captured at edge k+1.
//
// Ports:
//   clk            core clock, all state on the rising edge
//   reset          asynchronous, active-high reset
//   rom_addr       word address to the ROM (the pc register)
//   rom_data       ROM word for rom_addr
//   stall          decoder hold: freeze pc and all outputs
//   redirect       load pc from redirect_addr, squash the in-flight word
//   redirect_addr  absolute control-flow target
//   skip           squash the next captured word, pc keeps advancing
//   instr          instruction register
//   instr_valid    instr is a real instruction (0 = treat as NOP)
//   instr_pc       address of instr
//   instr_pc_next  instr_pc + 1 (rcall return address)
module fetch_unit #(
    parameter int ADDR_WIDTH = core_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = core_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    input  logic                  stall,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_addr,
    input  logic                  skip,
    output logic [DATA_WIDTH-1:0] instr,
    output logic                  instr_valid,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic [ADDR_WIDTH-1:0] instr_pc_next
);

    import core_pkg::*;

    fetch_state_t           state_q;
    logic [ADDR_WIDTH-1:0]  pc_q;
    logic [DATA_WIDTH-1:0]  instr_q;
    logic                   valid_q;
    logic [ADDR_WIDTH-1:0]  ipc_q;
    logic [ADDR_WIDTH-1:0]  ipcn_q;

    // Single incrementer: feeds the next pc and, registered alongside the
    // captured word, becomes instr_pc_next (instr_pc is the old pc).
    // Wraps naturally modulo 2^ADDR_WIDTH.
    logic [ADDR_WIDTH-1:0]  pc_inc;
    assign pc_inc = pc_q + ADDR_WIDTH'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_PRIME;
            pc_q    <= '0;
            instr_q <= DATA_WIDTH'(INSTR_NOP);
            valid_q <= 1'b0;
            ipc_q   <= '0;
            ipcn_q  <= ADDR_WIDTH'(1);
        end else begin
            case (state_q)
                // ROM output is not yet meaningful for address 0: spend one
                // edge letting it latch, without capturing or advancing.
                ST_PRIME: state_q <= ST_RUN;

                ST_RUN: begin
                    if (redirect) begin
                        // Redirect beats stall and skip. The in-flight word
                        // is still captured but marked invalid (the bubble).
                        pc_q    <= redirect_addr;
                        instr_q <= rom_data;
                        ipc_q   <= pc_q;
                        ipcn_q  <= pc_inc;
                        valid_q <= 1'b0;
                    end else if (!stall) begin
                        pc_q    <= pc_inc;
                        instr_q <= rom_data;
                        ipc_q   <= pc_q;
                        ipcn_q  <= pc_inc;
                        valid_q <= !skip;
                    end
                end

                default: state_q <= ST_PRIME;
            endcase
        end
    end

    assign rom_addr      = pc_q;
    assign instr         = instr_q;
    assign instr_valid   = valid_q;
    assign instr_pc      = ipc_q;
    assign instr_pc_next = ipcn_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam int AW = 8;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic          stall, redirect, skip;
    logic [AW-1:0] redirect_addr;
    logic [DW-1:0] instr;
    logic          instr_valid;
    logic [AW-1:0] instr_pc, instr_pc_next;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] rom [256];

    fetch_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .rom_addr(rom_addr), .rom_data(rom_data),
        .stall(stall), .redirect(redirect), .redirect_addr(redirect_addr),
        .skip(skip), .instr(instr), .instr_valid(instr_valid),
        .instr_pc(instr_pc), .instr_pc_next(instr_pc_next)
    );

    always #5 clk = ~clk;

    // Program ROM: output latched on the falling edge.
    always @(negedge clk) rom_data <= rom[rom_addr];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    bit       m_prime;
    int       m_pc, m_ipc;
    bit [15:0] m_instr;
    bit       m_valid;

    always @(posedge clk) begin
        bit r, rd, st, sk;
        int ra;
        r = reset; rd = redirect; st = stall; sk = skip; ra = int'(redirect_addr);
        if (r) begin
            m_prime = 1; m_pc = 0; m_ipc = 0; m_instr = 16'h0000; m_valid = 0;
        end else if (m_prime) begin
            m_prime = 0;
        end else if (rd) begin
            m_instr = rom[m_pc]; m_ipc = m_pc; m_valid = 0; m_pc = ra;
        end else if (!st) begin
            m_instr = rom[m_pc]; m_ipc = m_pc; m_valid = !sk; m_pc = (m_pc + 1) % 256;
        end
        #1;
        chk("rom_addr", 32'(rom_addr), 32'(m_pc));
        chk("instr_valid", 32'(instr_valid), 32'(m_valid));
        chk("instr_pc", 32'(instr_pc), 32'(m_ipc));
        chk("instr_pc_next", 32'(instr_pc_next), 32'((m_ipc + 1) % 256));
        chk("instr", 32'(instr), 32'(m_instr));
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk); #2;
    endtask

    task automatic drive(input bit rd, input bit st, input bit sk, input int ra);
        redirect = rd; stall = st; skip = sk; redirect_addr = AW'(ra);
    endtask

    initial begin
        bit prev_skip;
        for (int i = 0; i < 256; i++) rom[i] = DW'($urandom);
        rom[0] = 16'hC026; rom[1] = 16'hB7CD; rom[39] = 16'hEB0F; rom[255] = 16'h0000;
        reset = 1'b1;
        drive(0, 0, 0, 0);
        step(); step();
        chk("reset_instr", 32'(instr), 32'h0);
        chk("reset_valid", 32'(instr_valid), 32'h0);
        chk("reset_ipc_next", 32'(instr_pc_next), 32'h1);
        reset = 1'b0;

        step(); // PRIME -> RUN
        chk("prime_valid", 32'(instr_valid), 32'h0);
        chk("prime_pc", 32'(rom_addr), 32'h0);
        step();
        chk("first_instr", 32'(instr), 32'hC026);
        chk("first_valid", 32'(instr_valid), 32'h1);
        chk("first_ipc", 32'(instr_pc), 32'h0);
        step();
        chk("second_instr", 32'(instr), 32'hB7CD);
        chk("second_ipc", 32'(instr_pc), 32'h1);

        // redirect to 39
        drive(1, 0, 0, 39); step();
        chk("redir_bubble", 32'(instr_valid), 32'h0);
        drive(0, 0, 0, 0); step();
        chk("redir_instr", 32'(instr), 32'hEB0F);
        chk("redir_ipc", 32'(instr_pc), 32'd39);
        chk("redir_ipcn", 32'(instr_pc_next), 32'd40);

        // stall at instr_pc 5
        drive(1, 0, 0, 5); step();
        drive(0, 0, 0, 0); step();
        drive(0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_ipc", 32'(instr_pc), 32'd5);
            chk("stall_addr", 32'(rom_addr), 32'd6);
            chk("stall_instr", 32'(instr), 32'(rom[5]));
        end
        drive(0, 0, 0, 0); step();
        chk("unstall_ipc", 32'(instr_pc), 32'd6);
        chk("unstall_valid", 32'(instr_valid), 32'h1);

        // skip while pc = 7
        drive(0, 0, 1, 0); step();
        chk("skip_ipc", 32'(instr_pc), 32'd7);
        chk("skip_valid", 32'(instr_valid), 32'h0);
        drive(0, 0, 0, 0); step();
        chk("after_skip_ipc", 32'(instr_pc), 32'd8);
        chk("after_skip_valid", 32'(instr_valid), 32'h1);

        // redirect + stall together
        drive(1, 1, 0, 0); step();
        chk("rs_pc", 32'(rom_addr), 32'h0);
        chk("rs_valid", 32'(instr_valid), 32'h0);
        drive(0, 0, 0, 0); step();
        chk("rs_instr", 32'(instr), 32'hC026);

        // wrap at 255
        drive(1, 0, 0, 255); step();
        drive(0, 0, 0, 0); step();
        chk("wrap_ipc", 32'(instr_pc), 32'd255);
        chk("wrap_instr", 32'(instr), 32'h0);
        chk("wrap_valid", 32'(instr_valid), 32'h1);
        step();
        chk("wrap_ipc0", 32'(instr_pc), 32'd0);
        chk("wrap_ipcn", 32'(instr_pc_next), 32'd1);

        // asynchronous reset mid-run, with requests pending
        drive(1, 1, 1, 77);
        reset = 1'b1; #1;
        chk("async_valid", 32'(instr_valid), 32'h0);
        chk("async_pc", 32'(rom_addr), 32'h0);
        step();
        reset = 1'b0;
        drive(0, 0, 0, 0);

        // randomized run against the model
        prev_skip = 0;
        for (int i = 0; i < 3000; i++) begin
            bit sk;
            sk = !prev_skip && ($urandom_range(99) < 15);
            drive($urandom_range(99) < 10, $urandom_range(99) < 20, sk, int'($urandom_range(255)));
            prev_skip = sk;
            reset = ($urandom_range(199) == 0);
            step();
        end
        reset = 1'b0;
        drive(0, 0, 0, 0);
        step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
